// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from ID/EX and pipeline control outputs of pipeline_ctrl, bundled as one port.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [6:0]       OPCODE_ID;
    logic [4:0]       RS1_ID;
    logic [4:0]       RS2_ID;
    logic [4:0]       RD_EX;
    logic             MemRead_EX;
    logic             Branch_taken_EX;
    logic             mem_busy;
    logic             PC_write;
    logic             IF_ID_write;
    logic             pipeline_stall;
    logic             IF_ID_flush;
    logic             ID_EX_flush;
    logic             pipe_hold;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic             mem_timeout;

    modport master (
        output OPCODE_ID, RS1_ID, RS2_ID, RD_EX, MemRead_EX, Branch_taken_EX, mem_busy,
        input  PC_write, IF_ID_write, pipeline_stall, IF_ID_flush, ID_EX_flush, pipe_hold,
        input  state, stall_cycles, flush_count, mem_timeout
    );

    modport slave (
        input  OPCODE_ID, RS1_ID, RS2_ID, RD_EX, MemRead_EX, Branch_taken_EX, mem_busy,
        output PC_write, IF_ID_write, pipeline_stall, IF_ID_flush, ID_EX_flush, pipe_hold,
        output state, stall_cycles, flush_count, mem_timeout
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: memory hold, branch flush and load-use stall arbitration,
// with saturating performance counters and a sticky memory-timeout flag.
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pipeline_ctrl_if.slave bus
);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        FLUSH    = 2'b10,
        MEM_WAIT = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        ACT_RUN,
        ACT_STALL,
        ACT_FLUSH,
        ACT_HOLD
    } action_t;

    state_t             state_q;
    state_t             state_d;
    action_t            action;
    logic               pending_flush_q;
    logic               pending_flush_d;
    logic [WAIT_W-1:0]  wait_q;
    logic [CNT_W-1:0]   stall_q;
    logic [CNT_W-1:0]   flush_q;
    logic               timeout_q;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               load_use;
    logic               taken;

    // Hazard detection; load-use is masked in the cycle after a flush since ID holds a bubble.
    always_comb begin : hazard_detect
        uses_rs1 = !(bus.OPCODE_ID inside {OP_LUI, OP_AUIPC, OP_JAL});
        uses_rs2 = bus.OPCODE_ID inside {OP_OP, OP_STORE, OP_BRANCH};
        load_use = bus.MemRead_EX && (bus.RD_EX != 5'd0) &&
                   (((bus.RD_EX == bus.RS1_ID) && uses_rs1) ||
                    ((bus.RD_EX == bus.RS2_ID) && uses_rs2)) &&
                   (state_q != FLUSH);
        taken    = bus.Branch_taken_EX || pending_flush_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Action arbitration; reset forces the RUN action regardless of inputs.
    always_comb begin : next_state_logic
        state_d             = RUN;
        pending_flush_d     = pending_flush_q;
        action              = ACT_RUN;
        bus.PC_write        = 1'b1;
        bus.IF_ID_write     = 1'b1;
        bus.pipeline_stall  = 1'b0;
        bus.IF_ID_flush     = 1'b0;
        bus.ID_EX_flush     = 1'b0;
        bus.pipe_hold       = 1'b0;
        if (rst_n) begin
            if (bus.mem_busy) begin
                action          = ACT_HOLD;
                state_d         = MEM_WAIT;
                bus.PC_write    = 1'b0;
                bus.IF_ID_write = 1'b0;
                bus.pipe_hold   = 1'b1;
                if (bus.Branch_taken_EX) begin
                    pending_flush_d = 1'b1;
                end
            end else if (taken) begin
                action          = ACT_FLUSH;
                state_d         = FLUSH;
                pending_flush_d = 1'b0;
                bus.IF_ID_flush = 1'b1;
                bus.ID_EX_flush = 1'b1;
            end else if (load_use) begin
                action             = ACT_STALL;
                state_d            = LU_STALL;
                bus.PC_write       = 1'b0;
                bus.IF_ID_write    = 1'b0;
                bus.pipeline_stall = 1'b1;
            end
        end
    end

    // Pending flush, hold-length watchdog and saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin : status_regs
        if (!rst_n) begin
            pending_flush_q <= 1'b0;
            wait_q          <= '0;
            stall_q         <= '0;
            flush_q         <= '0;
            timeout_q       <= 1'b0;
        end else begin
            pending_flush_q <= pending_flush_d;
            if (action == ACT_HOLD) begin
                if (wait_q != WAIT_W'(TIMEOUT)) begin
                    wait_q <= wait_q + WAIT_W'(1);
                end
                if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_q <= 1'b1;
                end
            end else begin
                wait_q <= '0;
            end
            if (((action == ACT_HOLD) || (action == ACT_STALL)) && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if ((action == ACT_FLUSH) && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign bus.state        = state_q;
    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;
    assign bus.mem_timeout  = timeout_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: inputs change on the falling edge,
// combinational outputs are checked just after, registered outputs after each rising edge.
module tb_pipeline_ctrl;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    pipeline_ctrl_if #(.CNT_W(16)) bus ();

    pipeline_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.OPCODE_ID       = 7'b0110011;
        bus.RS1_ID          = 5'd1;
        bus.RS2_ID          = 5'd2;
        bus.RD_EX           = 5'd0;
        bus.MemRead_EX      = 1'b0;
        bus.Branch_taken_EX = 1'b0;
        bus.mem_busy        = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.mem_busy = 1'b1; bus.Branch_taken_EX = 1'b1;
        bus.MemRead_EX = 1'b1; bus.RD_EX = 5'd2;
        cyc();
        vectors++; if (bus.state !== 2'b00) begin miscompares++; $display("FAIL rst_state got %0d exp 0", bus.state); end
        vectors++; if (bus.PC_write !== 1'b1) begin miscompares++; $display("FAIL rst_pc_write got %0b exp 1", bus.PC_write); end
        vectors++; if (bus.IF_ID_write !== 1'b1) begin miscompares++; $display("FAIL rst_ifid_write got %0b exp 1", bus.IF_ID_write); end
        vectors++; if (bus.pipe_hold !== 1'b0) begin miscompares++; $display("FAIL rst_pipe_hold got %0b exp 0", bus.pipe_hold); end
        vectors++; if (bus.IF_ID_flush !== 1'b0) begin miscompares++; $display("FAIL rst_ifid_flush got %0b exp 0", bus.IF_ID_flush); end
        vectors++; if (bus.pipeline_stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %0b exp 0", bus.pipeline_stall); end
        vectors++; if (bus.stall_cycles !== 16'd0) begin miscompares++; $display("FAIL rst_stall_cycles got %0d exp 0", bus.stall_cycles); end
        vectors++; if (bus.flush_count !== 16'd0) begin miscompares++; $display("FAIL rst_flush_count got %0d exp 0", bus.flush_count); end
        vectors++; if (bus.mem_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout got %0b exp 0", bus.mem_timeout); end
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        bus.MemRead_EX = 1'b1; bus.RD_EX = 5'd5; bus.OPCODE_ID = 7'b0110011; bus.RS2_ID = 5'd5;
        #1;
        vectors++; if (bus.pipeline_stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall got %0b exp 1", bus.pipeline_stall); end
        vectors++; if (bus.PC_write !== 1'b0) begin miscompares++; $display("FAIL lu_pc_write got %0b exp 0", bus.PC_write); end
        vectors++; if (bus.IF_ID_write !== 1'b0) begin miscompares++; $display("FAIL lu_ifid_write got %0b exp 0", bus.IF_ID_write); end
        vectors++; if (bus.ID_EX_flush !== 1'b0) begin miscompares++; $display("FAIL lu_idex_flush got %0b exp 0", bus.ID_EX_flush); end
        cyc();
        vectors++; if (bus.state !== 2'b01) begin miscompares++; $display("FAIL lu_state got %0d exp 1", bus.state); end
        vectors++; if (bus.stall_cycles !== 16'd1) begin miscompares++; $display("FAIL lu_stall_cycles got %0d exp 1", bus.stall_cycles); end
        bus.MemRead_EX = 1'b0;
        #1;
        vectors++; if (bus.PC_write !== 1'b1) begin miscompares++; $display("FAIL lu_release_pc got %0b exp 1", bus.PC_write); end
        cyc();
        vectors++; if (bus.state !== 2'b00) begin miscompares++; $display("FAIL lu_back_run got %0d exp 0", bus.state); end
    endtask

    task automatic test_operand_use();
        do_reset();
        // Zero destination register never stalls.
        bus.MemRead_EX = 1'b1; bus.RD_EX = 5'd0; bus.OPCODE_ID = 7'b0110011; bus.RS2_ID = 5'd0;
        #1;
        vectors++; if (bus.pipeline_stall !== 1'b0) begin miscompares++; $display("FAIL x0_stall got %0b exp 0", bus.pipeline_stall); end
        cyc();
        vectors++; if (bus.state !== 2'b00) begin miscompares++; $display("FAIL x0_state got %0d exp 0", bus.state); end
        // LUI does not read rs1.
        bus.RD_EX = 5'd7; bus.OPCODE_ID = 7'b0110111; bus.RS1_ID = 5'd7; bus.RS2_ID = 5'd7;
        #1;
        vectors++; if (bus.pipeline_stall !== 1'b0) begin miscompares++; $display("FAIL lui_stall got %0b exp 0", bus.pipeline_stall); end
        // Load (I-type) reads rs1 but not rs2.
        bus.OPCODE_ID = 7'b0000011; bus.RS1_ID = 5'd1; bus.RS2_ID = 5'd7;
        #1;
        vectors++; if (bus.pipeline_stall !== 1'b0) begin miscompares++; $display("FAIL itype_rs2_stall got %0b exp 0", bus.pipeline_stall); end
        bus.RS1_ID = 5'd7; bus.RS2_ID = 5'd3;
        #1;
        vectors++; if (bus.pipeline_stall !== 1'b1) begin miscompares++; $display("FAIL itype_rs1_stall got %0b exp 1", bus.pipeline_stall); end
        // Store reads rs2.
        bus.OPCODE_ID = 7'b0100011; bus.RS1_ID = 5'd1; bus.RS2_ID = 5'd7;
        #1;
        vectors++; if (bus.pipeline_stall !== 1'b1) begin miscompares++; $display("FAIL store_rs2_stall got %0b exp 1", bus.pipeline_stall); end
        bus.MemRead_EX = 1'b0;
        #1;
        vectors++; if (bus.pipeline_stall !== 1'b0) begin miscompares++; $display("FAIL noload_stall got %0b exp 0", bus.pipeline_stall); end
        idle_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        bus.Branch_taken_EX = 1'b1;
        #1;
        vectors++; if (bus.IF_ID_flush !== 1'b1) begin miscompares++; $display("FAIL br_ifid_flush got %0b exp 1", bus.IF_ID_flush); end
        vectors++; if (bus.ID_EX_flush !== 1'b1) begin miscompares++; $display("FAIL br_idex_flush got %0b exp 1", bus.ID_EX_flush); end
        vectors++; if (bus.PC_write !== 1'b1) begin miscompares++; $display("FAIL br_pc_write got %0b exp 1", bus.PC_write); end
        cyc();
        vectors++; if (bus.state !== 2'b10) begin miscompares++; $display("FAIL br_state got %0d exp 2", bus.state); end
        vectors++; if (bus.flush_count !== 16'd1) begin miscompares++; $display("FAIL br_flush_count got %0d exp 1", bus.flush_count); end
        bus.Branch_taken_EX = 1'b0;
        bus.MemRead_EX = 1'b1; bus.RD_EX = 5'd5; bus.RS2_ID = 5'd5;
        #1;
        vectors++; if (bus.pipeline_stall !== 1'b0) begin miscompares++; $display("FAIL br_lu_masked got %0b exp 0", bus.pipeline_stall); end
        vectors++; if (bus.IF_ID_flush !== 1'b0) begin miscompares++; $display("FAIL br_single_flush got %0b exp 0", bus.IF_ID_flush); end
        cyc();
        vectors++; if (bus.state !== 2'b00) begin miscompares++; $display("FAIL br_after_state got %0d exp 0", bus.state); end
        vectors++; if (bus.stall_cycles !== 16'd0) begin miscompares++; $display("FAIL br_stall_cycles got %0d exp 0", bus.stall_cycles); end
        #1;
        vectors++; if (bus.pipeline_stall !== 1'b1) begin miscompares++; $display("FAIL br_lu_resumes got %0b exp 1", bus.pipeline_stall); end
        idle_inputs();
    endtask

    task automatic test_branch_during_hold();
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            bus.mem_busy = 1'b1;
            bus.Branch_taken_EX = (c == 2);
            #1;
            vectors++; if (bus.pipe_hold !== 1'b1) begin miscompares++; $display("FAIL bh_pipe_hold c%0d got %0b exp 1", c, bus.pipe_hold); end
            vectors++; if (bus.IF_ID_flush !== 1'b0) begin miscompares++; $display("FAIL bh_no_flush c%0d got %0b exp 0", c, bus.IF_ID_flush); end
            cyc();
        end
        vectors++; if (bus.state !== 2'b11) begin miscompares++; $display("FAIL bh_state_wait got %0d exp 3", bus.state); end
        bus.mem_busy = 1'b0; bus.Branch_taken_EX = 1'b0;
        #1;
        vectors++; if (bus.IF_ID_flush !== 1'b1) begin miscompares++; $display("FAIL bh_flush got %0b exp 1", bus.IF_ID_flush); end
        vectors++; if (bus.pipe_hold !== 1'b0) begin miscompares++; $display("FAIL bh_hold_off got %0b exp 0", bus.pipe_hold); end
        cyc();
        vectors++; if (bus.state !== 2'b10) begin miscompares++; $display("FAIL bh_state_flush got %0d exp 2", bus.state); end
        vectors++; if (bus.flush_count !== 16'd1) begin miscompares++; $display("FAIL bh_flush_count got %0d exp 1", bus.flush_count); end
        vectors++; if (bus.stall_cycles !== 16'd4) begin miscompares++; $display("FAIL bh_stall_cycles got %0d exp 4", bus.stall_cycles); end
        #1;
        vectors++; if (bus.IF_ID_flush !== 1'b0) begin miscompares++; $display("FAIL bh_one_flush got %0b exp 0", bus.IF_ID_flush); end
    endtask

    task automatic test_hold_then_stall();
        do_reset();
        bus.MemRead_EX = 1'b1; bus.RD_EX = 5'd9; bus.RS1_ID = 5'd9;
        bus.mem_busy = 1'b1;
        #1;
        vectors++; if (bus.pipeline_stall !== 1'b0) begin miscompares++; $display("FAIL hs_hold_prio got %0b exp 0", bus.pipeline_stall); end
        cyc(); cyc();
        bus.mem_busy = 1'b0;
        #1;
        vectors++; if (bus.pipeline_stall !== 1'b1) begin miscompares++; $display("FAIL hs_stall got %0b exp 1", bus.pipeline_stall); end
        cyc();
        vectors++; if (bus.state !== 2'b01) begin miscompares++; $display("FAIL hs_state got %0d exp 1", bus.state); end
        vectors++; if (bus.stall_cycles !== 16'd3) begin miscompares++; $display("FAIL hs_stall_cycles got %0d exp 3", bus.stall_cycles); end
        idle_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.mem_busy = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            vectors++; if (bus.mem_timeout !== (k >= 16)) begin miscompares++; $display("FAIL to_edge%0d got %0b exp %0b", k, bus.mem_timeout, (k >= 16)); end
        end
        bus.mem_busy = 1'b0;
        cyc(); cyc(); cyc();
        vectors++; if (bus.mem_timeout !== 1'b1) begin miscompares++; $display("FAIL to_sticky got %0b exp 1", bus.mem_timeout); end
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.mem_timeout !== 1'b0) begin miscompares++; $display("FAIL to_async_clear got %0b exp 0", bus.mem_timeout); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wait_clear();
        do_reset();
        bus.mem_busy = 1'b1;
        repeat (15) cyc();
        bus.mem_busy = 1'b0;
        cyc();
        bus.mem_busy = 1'b1;
        repeat (15) cyc();
        vectors++; if (bus.mem_timeout !== 1'b0) begin miscompares++; $display("FAIL wc_gap_clears got %0b exp 0", bus.mem_timeout); end
        // Reset mid-hold drops both the wait count and a pending branch.
        do_reset();
        bus.mem_busy = 1'b1;
        cyc();
        bus.Branch_taken_EX = 1'b1;
        repeat (9) begin cyc(); bus.Branch_taken_EX = 1'b0; end
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.state !== 2'b00) begin miscompares++; $display("FAIL wc_rst_state got %0d exp 0", bus.state); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_busy = 1'b1;
        repeat (10) cyc();
        vectors++; if (bus.mem_timeout !== 1'b0) begin miscompares++; $display("FAIL wc_rst_count got %0b exp 0", bus.mem_timeout); end
        bus.mem_busy = 1'b0;
        #1;
        vectors++; if (bus.IF_ID_flush !== 1'b0) begin miscompares++; $display("FAIL wc_rst_pending got %0b exp 0", bus.IF_ID_flush); end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.MemRead_EX = 1'b1; bus.RD_EX = 5'd5; bus.RS2_ID = 5'd5;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        vectors++; if (bus.stall_cycles !== 16'hFFFF) begin miscompares++; $display("FAIL sat_value got %0h exp ffff", bus.stall_cycles); end
        vectors++; if (bus.state !== 2'b01) begin miscompares++; $display("FAIL sat_state got %0d exp 1", bus.state); end
        cyc();
        vectors++; if (bus.stall_cycles !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold got %0h exp ffff", bus.stall_cycles); end
        idle_inputs();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_operand_use();
        test_branch();
        test_branch_during_hold();
        test_hold_then_stall();
        test_timeout();
        test_wait_clear();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: consecutive mem_busy cycles that set mem_timeout.
REQ-002 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port OPCODE_ID, input, 7: opcode of the instruction in ID.
REQ-006 SHALL have ports RS1_ID and RS2_ID, input, 5 each: source registers of the instruction in ID.
REQ-007 SHALL have ports RD_EX (input, 5) and MemRead_EX (input, 1): destination register and load flag of the instruction in EX.
REQ-008 SHALL have port Branch_taken_EX, input, 1: single-cycle pulse marking a taken branch or jump resolved in EX.
REQ-009 SHALL have port mem_busy, input, 1: data memory not ready; the whole pipeline must freeze.
REQ-010 SHALL have ports PC_write and IF_ID_write, output, 1 each: enables for the PC and IF/ID registers.
REQ-011 SHALL have port pipeline_stall, output, 1: forces ID control signals to zero (bubble into EX).
REQ-012 SHALL have ports IF_ID_flush and ID_EX_flush, output, 1 each: clear the respective pipeline registers.
REQ-013 SHALL have port pipe_hold, output, 1: freezes ID/EX, EX/MEM and MEM/WB.
REQ-014 SHALL have port state, output, 2: current FSM state.
REQ-015 SHALL have ports stall_cycles and flush_count, output, CNT_W each: performance counters.
REQ-016 SHALL have port mem_timeout, output, 1: sticky error flag.

Function
REQ-017 SHALL encode FSM states as RUN=00, LU_STALL=01, FLUSH=10, MEM_WAIT=11.
REQ-018 SHALL define uses_rs1 as OPCODE_ID not in {0110111, 0010111, 1101111}.
REQ-019 SHALL define uses_rs2 as OPCODE_ID in {0110011, 0100011, 1100011}.
REQ-020 SHALL define load_use as MemRead_EX && RD_EX!=0 && ((RD_EX==RS1_ID && uses_rs1) || (RD_EX==RS2_ID && uses_rs2)), forced to 0 while state==FLUSH.
REQ-021 SHALL hold an internal pending_flush bit, and SHALL define taken as Branch_taken_EX || pending_flush.
REQ-022 SHALL select exactly one action per cycle, combinationally, in priority order: HOLD (mem_busy), then FLUSH (taken), then STALL (load_use), then RUN.
REQ-023 HOLD SHALL drive PC_write=0, IF_ID_write=0, pipe_hold=1, all other controls 0; next state MEM_WAIT; pending_flush set if Branch_taken_EX=1, otherwise kept.
REQ-024 FLUSH SHALL drive PC_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_flush=1, pipeline_stall=0, pipe_hold=0; next state FLUSH; pending_flush cleared; flush_count incremented.
REQ-025 STALL SHALL drive PC_write=0, IF_ID_write=0, pipeline_stall=1, flushes 0, pipe_hold=0; next state LU_STALL.
REQ-026 RUN SHALL drive PC_write=1, IF_ID_write=1, all other controls 0; next state RUN.
REQ-027 stall_cycles SHALL increment on every HOLD or STALL cycle.
REQ-028 Both counters SHALL saturate at all-ones, never wrapping.
REQ-029 An internal wait counter SHALL count consecutive HOLD cycles, and SHALL clear on any cycle with mem_busy=0.
REQ-030 mem_timeout SHALL set on the edge at which the wait counter reaches TIMEOUT, and SHALL remain 1 until reset.
REQ-031 A load-use hazard present at mem_busy deassertion SHALL produce exactly one STALL cycle after the HOLD cycles.
REQ-032 A Branch_taken_EX pulse during mem_busy SHALL produce exactly one FLUSH cycle on the first cycle with mem_busy=0.

Reset
REQ-033 While rst_n=0, state SHALL be RUN (00), and pending_flush, the wait counter, stall_cycles, flush_count and mem_timeout SHALL be 0, asynchronously.
REQ-034 While rst_n=0, combinational outputs SHALL follow the RUN action: PC_write=1, IF_ID_write=1, others 0.
REQ-035 Reset asserted mid-HOLD or mid-flush SHALL discard pending_flush and the wait count immediately.

Verification
REQ-036 Load-use: MemRead_EX=1, RD_EX=5, OPCODE_ID=0110011, RS2_ID=5 -> one cycle of pipeline_stall=1, PC_write=0, IF_ID_write=0, state->01; stall_cycles=1.
REQ-037 Zero register: the REQ-036 stimulus with RD_EX=0 -> no stall; state stays 00.
REQ-038 Branch: Branch_taken_EX pulse -> IF_ID_flush=ID_EX_flush=1 that cycle, state->10, flush_count=1; a load_use condition on the next cycle is ignored.
REQ-039 Branch during HOLD: Branch_taken_EX pulse in cycle 2 of a 4-cycle mem_busy -> pipe_hold=1 for 4 cycles, then exactly one flush cycle; stall_cycles=4.
REQ-040 Timeout: mem_busy held 20 cycles -> mem_timeout=1 from the 16th edge; it stays 1 after mem_busy drops, until rst_n=0.
REQ-041 Saturation: 70000 consecutive STALL cycles -> stall_cycles=0xFFFF and held there.
